vote_round_controller: RTL and testbench
========================================

Name: vote_round_controller

Overview:
- Shares one bitwise pair/triple (2-of-3 majority) vote unit among three requesters.
- Round-robin arbitrates one vote capture per cycle into three slots.
- Once all slots are filled, or a timeout expires, it applies the majority function and presents the result on a val/rdy output interface.
- Sits between redundant producers and downstream consumers in the lab datapath.

Parameters:
- NBITS, 8: width of each vote message; majority is applied per bit.
- TIMEOUT, 16: cycles allowed in COLLECT after the first capture before forcing a vote; 0 disables the timeout.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_val  input  1  requester 0 vote valid
- req0_rdy  output  1  requester 0 vote accepted this cycle
- req0_msg  input  NBITS  requester 0 vote
- req1_val, req1_rdy, req1_msg: same as requester 0, for requester 1
- req2_val, req2_rdy, req2_msg: same as requester 0, for requester 2
- out_val  output  1  result valid
- out_rdy  input  1  consumer ready
- out_msg  output  NBITS  bitwise majority of the three slots
- out_agree  output  1  all three slots present and identical
- out_timeout  output  1  round closed by timeout

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst. On rst=1 at a clock edge:
  - state=COLLECT; slot valid bits cleared; slot data cleared to 0.
  - priority pointer=0; timeout counter=0.
  - out_val=0, out_msg=0, out_agree=0, out_timeout=0.
  - All reqN_rdy are 0 during the reset cycle.
- Reset mid-round discards all captured votes and any pending output.
- States: COLLECT and RESULT.
- COLLECT:
  - Eligible requester: reqN_val=1 and slot N empty.
  - The round-robin grant picks the first eligible requester starting at the pointer. Only the granted reqN_rdy=1; all others are 0.
  - Handshake fires when val and rdy are both 1. The slot captures msg and sets its valid bit. The pointer moves to (granted+1) mod 3.
  - No grant leaves the pointer unchanged.
  - reqN_rdy must be a combinational function of state, slot valids, pointer and the reqN_val inputs only.
- Timeout:
  - Counter resets to 0 at the first capture of a round and increments each COLLECT cycle while at least one slot is filled.
  - When the counter reaches TIMEOUT−1 with the round incomplete, go to RESULT next cycle with out_timeout=1.
  - A capture that completes all three slots in the same cycle as expiry wins: out_timeout=0.
- Transition to RESULT occurs the cycle after the third capture (latency 1). out_val=1 in the first RESULT cycle.
- Result values, registered on entry to RESULT:
  - out_msg[i] = (s0&s1) | (s2&(s0|s1)), where an empty slot reads as 0.
  - out_agree = 1 only if all three slots are valid and equal.
- RESULT:
  - All reqN_rdy=0; out_val, out_msg, out_agree and out_timeout are held stable until out_val&out_rdy.
  - On that handshake: clear slots and counter, set out_val=0, return to COLLECT. The pointer is retained.
  - New captures are possible the cycle after the handshake, not the same cycle.
- A timeout round with zero captures never occurs, because the counter is idle while all slots are empty.
- Requesters may drop val without a handshake; a vote is only captured on val&rdy.

Optional Feature:
- Macro: VOTE_ROUND_CONTROLLER_DISAGREE_COUNT_EN.
- When defined:
  - Adds output port disagree_count (8 bits).
  - It is a saturating counter, reset to 0, incremented on each output handshake where out_agree=0. It holds at 255.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding constants STATE_COLLECT=0 and STATE_RESULT=1;
  - requester count constant NREQ=3.
- Natural sub-module: vote_round_controller_rr_arb, a 3-way round-robin arbiter taking eligible bits and the pointer and producing a one-hot grant.
- The majority function itself is inline gate-level logic per bit.

Test Plan:
- Reset then idle: all outputs 0 and reqN_rdy=0 during reset; after reset with all val=0, out_val stays 0 for 40 cycles.
- All three val=1 on the same cycle with msgs 0x0F, 0x3C, 0xF0:
  - grants in order 0, 1, 2 on consecutive cycles;
  - out_val=1 one cycle after the third grant, out_msg=0x3C, out_agree=0, out_timeout=0.
- Identical votes 0xA5 ×3 with out_rdy held 0 for 5 cycles: out_val, out_msg=0xA5 and out_agree=1 stable; reqN_rdy=0 throughout; the handshake on cycle 6 returns to COLLECT.
- TIMEOUT=16; only req0=0xFF and req1=0x0F arrive:
  - RESULT is entered 16 cycles after the first capture;
  - out_msg=0x0F, out_timeout=1, out_agree=0.
- Fairness: req0 val held continuously across rounds while req1 and req2 also request. Each round grants each requester once, and the starting requester follows the pointer left by the previous round.
- rst asserted in the cycle after two captures: the next round starts empty, with a fresh timeout count and no stale out_val.

Source files
------------

// File: rtl/vote_round_controller_pkg.sv
// Shared types and constants for the vote round controller.
// Holds the FSM state encoding and the requester count.
package vote_round_controller_pkg;

  typedef enum logic {
    STATE_COLLECT = 1'b0,
    STATE_RESULT  = 1'b1
  } state_e;

  localparam int NREQ = 3;

  // Pointer value that follows a one-hot grant.
  function automatic logic [1:0] ptr_after(
    input logic [NREQ-1:0] grant,
    input logic [1:0]      ptr
  );
    logic [1:0] r;
    r = ptr;
    unique case (1'b1)
      grant[0]: r = 2'd1;
      grant[1]: r = 2'd2;
      grant[2]: r = 2'd0;
      default:  r = ptr;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vote_round_controller_if.sv
// Vote requester and result handshake bundle.
// master drives votes and out_rdy; slave is the controller.
interface vote_round_controller_if #(
  parameter int NBITS = 8
);
  logic             req0_val;
  logic             req0_rdy;
  logic [NBITS-1:0] req0_msg;
  logic             req1_val;
  logic             req1_rdy;
  logic [NBITS-1:0] req1_msg;
  logic             req2_val;
  logic             req2_rdy;
  logic [NBITS-1:0] req2_msg;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_msg;
  logic             out_agree;
  logic             out_timeout;

  modport master (
    output req0_val, req0_msg,
    output req1_val, req1_msg,
    output req2_val, req2_msg,
    output out_rdy,
    input  req0_rdy, req1_rdy, req2_rdy,
    input  out_val, out_msg, out_agree, out_timeout
  );

  modport slave (
    input  req0_val, req0_msg,
    input  req1_val, req1_msg,
    input  req2_val, req2_msg,
    input  out_rdy,
    output req0_rdy, req1_rdy, req2_rdy,
    output out_val, out_msg, out_agree, out_timeout
  );
endinterface

// File: rtl/vote_round_controller_rr_arb.sv
// Three-way round-robin arbiter.
// One-hot grant to the first eligible requester from ptr_i.
module vote_round_controller_rr_arb
  import vote_round_controller_pkg::*;
(
  input  logic [NREQ-1:0] elig_i,
  input  logic [1:0]      ptr_i,
  output logic [NREQ-1:0] grant_o
);

  // Priority scan rotated to start at the pointer.
  always_comb begin
    grant_o = '0;
    unique case (ptr_i)
      2'd1: begin
        if (elig_i[1])      grant_o = 3'b010;
        else if (elig_i[2]) grant_o = 3'b100;
        else if (elig_i[0]) grant_o = 3'b001;
      end
      2'd2: begin
        if (elig_i[2])      grant_o = 3'b100;
        else if (elig_i[0]) grant_o = 3'b001;
        else if (elig_i[1]) grant_o = 3'b010;
      end
      default: begin
        if (elig_i[0])      grant_o = 3'b001;
        else if (elig_i[1]) grant_o = 3'b010;
        else if (elig_i[2]) grant_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/vote_round_controller.sv
// Collects three redundant votes and emits their bitwise 2-of-3 majority.
// Option: VOTE_ROUND_CONTROLLER_DISAGREE_COUNT_EN adds disagree_count.
module vote_round_controller
  import vote_round_controller_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  vote_round_controller_if.slave vif
`ifdef VOTE_ROUND_CONTROLLER_DISAGREE_COUNT_EN
  ,
  output logic [7:0] disagree_count
`endif
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           state_q;
  logic [NREQ-1:0]  vld_q;
  logic [NBITS-1:0] slot_q [NREQ];
  logic [1:0]       ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             oval_q;
  logic [NBITS-1:0] omsg_q;
  logic             oagree_q;
  logic             oto_q;

  logic [NREQ-1:0]  val;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;
  logic [NBITS-1:0] msg [NREQ];
  logic [NREQ-1:0]  vld_d;
  logic [NBITS-1:0] slot_d [NREQ];
  logic [NBITS-1:0] maj_d;
  logic             agree_d;
  logic             full_d;
  logic             expire;

  assign val    = {vif.req2_val, vif.req1_val, vif.req0_val};
  assign msg[0] = vif.req0_msg;
  assign msg[1] = vif.req1_msg;
  assign msg[2] = vif.req2_msg;

  // Only empty slots compete, and never outside COLLECT or in reset.
  assign elig = val & ~vld_q
              & {NREQ{(state_q == STATE_COLLECT) && !rst}};

  vote_round_controller_rr_arb u_arb (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign vif.req0_rdy = grant[0];
  assign vif.req1_rdy = grant[1];
  assign vif.req2_rdy = grant[2];

  // Slot contents as they will be after this cycle's capture.
  always_comb begin
    vld_d  = vld_q;
    slot_d = slot_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        vld_d[i]  = 1'b1;
        slot_d[i] = msg[i];
      end
    end
    maj_d = (slot_d[0] & slot_d[1])
          | (slot_d[2] & (slot_d[0] | slot_d[1]));
    full_d  = &vld_d;
    agree_d = full_d && (slot_d[0] == slot_d[1])
                     && (slot_d[1] == slot_d[2]);
    expire  = (TIMEOUT != 0) && (|vld_q)
           && (cnt_q == CW'(TIMEOUT - 1));
  end

  // Round FSM: capture votes, close on full or expiry, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STATE_COLLECT;
      vld_q    <= '0;
      slot_q   <= '{default: '0};
      ptr_q    <= 2'd0;
      cnt_q    <= '0;
      oval_q   <= 1'b0;
      omsg_q   <= '0;
      oagree_q <= 1'b0;
      oto_q    <= 1'b0;
    end else begin
      unique case (state_q)
        STATE_COLLECT: begin
          vld_q  <= vld_d;
          slot_q <= slot_d;
          ptr_q  <= ptr_after(grant, ptr_q);
          if ((|grant) && !(|vld_q))
            cnt_q <= '0;
          else if (|vld_q)
            cnt_q <= cnt_q + CW'(1);
          if (full_d || expire) begin
            state_q  <= STATE_RESULT;
            oval_q   <= 1'b1;
            omsg_q   <= maj_d;
            oagree_q <= agree_d;
            oto_q    <= !full_d;
          end
        end
        STATE_RESULT: begin
          if (vif.out_rdy) begin
            state_q <= STATE_COLLECT;
            vld_q   <= '0;
            slot_q  <= '{default: '0};
            cnt_q   <= '0;
            oval_q  <= 1'b0;
          end
        end
        default: state_q <= STATE_COLLECT;
      endcase
    end
  end

  assign vif.out_val     = oval_q;
  assign vif.out_msg     = omsg_q;
  assign vif.out_agree   = oagree_q;
  assign vif.out_timeout = oto_q;

`ifdef VOTE_ROUND_CONTROLLER_DISAGREE_COUNT_EN
  logic [7:0] dis_q;

  // Saturating count of delivered results that were not unanimous.
  always_ff @(posedge clk) begin
    if (rst)
      dis_q <= '0;
    else if (oval_q && vif.out_rdy && !oagree_q && dis_q != 8'hFF)
      dis_q <= dis_q + 8'd1;
  end

  assign disagree_count = dis_q;
`endif

endmodule

// File: tb/tb_vote_round_controller.sv
// Bench for vote_round_controller: directed rounds with a round-level
// model checked every cycle plus literal expectations.
module tb_vote_round_controller;

  localparam int NB = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vote_round_controller_if #(.NBITS(NB)) vif ();

  vote_round_controller #(
    .NBITS   (NB),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  function automatic logic [2:0] rdy_vec();
    return {vif.req2_rdy, vif.req1_rdy, vif.req0_rdy};
  endfunction

  // Round-level reference model
  bit         m_known = 1'b0;
  bit         m_res   = 1'b0;
  bit   [2:0] m_have  = '0;
  logic [7:0] m_data [3];
  int         m_ptr   = 0;
  int         m_first = 0;
  int         m_edge  = 0;
  logic       m_oval, m_oagree, m_oto;
  logic [7:0] m_omsg;

  function automatic logic [7:0] majority(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] c);
    logic [7:0] r;
    int ones;
    for (int i = 0; i < 8; i++) begin
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  function automatic int pick(input logic [2:0] v, input bit [2:0] have,
                              input int ptr);
    int r;
    for (int k = 0; k < 3; k++) begin
      r = (ptr + k) % 3;
      if (v[r] && !have[r]) return r;
    end
    return -1;
  endfunction

  // Compare DUT to model mid-cycle, then step the model across the edge.
  always @(negedge clk) begin
    logic [2:0] v;
    logic [2:0] rexp;
    logic [7:0] m [3];
    int g;
    bit had, full, to;
    v    = {vif.req2_val, vif.req1_val, vif.req0_val};
    m[0] = vif.req0_msg;
    m[1] = vif.req1_msg;
    m[2] = vif.req2_msg;
    rexp = '0;
    g    = -1;
    if (!rst && !m_res) begin
      g = pick(v, m_have, m_ptr);
      if (g >= 0) rexp[g] = 1'b1;
    end
    chk("model_rdy", {29'b0, rdy_vec()}, {29'b0, rexp});
    if (m_known) begin
      chk("model_out_val", {31'b0, vif.out_val}, {31'b0, m_oval});
      chk("model_out_msg", {24'b0, vif.out_msg}, {24'b0, m_omsg});
      chk("model_out_agree", {31'b0, vif.out_agree}, {31'b0, m_oagree});
      chk("model_out_timeout", {31'b0, vif.out_timeout}, {31'b0, m_oto});
    end
    if (rst) begin
      m_known  = 1'b1;
      m_res    = 1'b0;
      m_have   = '0;
      m_data   = '{default: '0};
      m_ptr    = 0;
      m_oval   = 1'b0;
      m_omsg   = '0;
      m_oagree = 1'b0;
      m_oto    = 1'b0;
    end else if (m_res) begin
      if (vif.out_rdy) begin
        m_res  = 1'b0;
        m_have = '0;
        m_data = '{default: '0};
        m_oval = 1'b0;
      end
    end else begin
      had = |m_have;
      if (g >= 0) begin
        m_have[g] = 1'b1;
        m_data[g] = m[g];
        m_ptr     = (g + 1) % 3;
        if (!had) m_first = m_edge;
      end
      full = &m_have;
      to   = !full && had && (TO != 0) && (m_edge - m_first == TO);
      if (full || to) begin
        m_res    = 1'b1;
        m_oval   = 1'b1;
        m_omsg   = majority(m_data[0], m_data[1], m_data[2]);
        m_oagree = full && (m_data[0] == m_data[1])
                        && (m_data[1] == m_data[2]);
        m_oto    = to;
      end
    end
    m_edge++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input logic [2:0] v);
    vif.req0_val = v[0];
    vif.req1_val = v[1];
    vif.req2_val = v[2];
  endtask

  task automatic setm(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c);
    vif.req0_msg = a;
    vif.req1_msg = b;
    vif.req2_msg = c;
  endtask

  initial begin
    logic [2:0] exp5 [8];
    int n;
    exp5[0] = 3'b100; exp5[1] = 3'b001;
    exp5[2] = 3'b010; exp5[3] = 3'b000;
    exp5[4] = 3'b100; exp5[5] = 3'b001;
    exp5[6] = 3'b010; exp5[7] = 3'b000;

    // Reset with requests pending, then idle
    rst = 1'b1;
    vif.out_rdy = 1'b0;
    setm(8'h0, 8'h0, 8'h0);
    setv(3'b111);
    repeat (3) step();
    #1;
    chk("rst_rdy", {29'b0, rdy_vec()}, 32'h0);
    chk("rst_out_val", {31'b0, vif.out_val}, 32'h0);
    chk("rst_out_msg", {24'b0, vif.out_msg}, 32'h0);
    rst = 1'b0;
    setv(3'b000);
    repeat (40) step();
    #1;
    chk("idle_out_val", {31'b0, vif.out_val}, 32'h0);

    // Three distinct votes, same cycle
    setm(8'h0F, 8'h3C, 8'hF0);
    setv(3'b111);
    #1; chk("mix_grant0", {29'b0, rdy_vec()}, 32'h1);
    step(); setv(3'b110);
    #1; chk("mix_grant1", {29'b0, rdy_vec()}, 32'h2);
    step(); setv(3'b100);
    #1; chk("mix_grant2", {29'b0, rdy_vec()}, 32'h4);
    step(); setv(3'b000);
    #1;
    chk("mix_out_val", {31'b0, vif.out_val}, 32'h1);
    chk("mix_out_msg", {24'b0, vif.out_msg}, 32'h3C);
    chk("mix_out_agree", {31'b0, vif.out_agree}, 32'h0);
    chk("mix_out_timeout", {31'b0, vif.out_timeout}, 32'h0);
    vif.out_rdy = 1'b1;
    step();
    vif.out_rdy = 1'b0;
    #1; chk("mix_drain", {31'b0, vif.out_val}, 32'h0);

    // Unanimous round held under backpressure
    setm(8'hA5, 8'hA5, 8'hA5);
    setv(3'b111); step();
    setv(3'b110); step();
    setv(3'b100); step();
    setm(8'h11, 8'h11, 8'h11);
    setv(3'b111);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_out_val", {31'b0, vif.out_val}, 32'h1);
      chk("hold_out_msg", {24'b0, vif.out_msg}, 32'hA5);
      chk("hold_out_agree", {31'b0, vif.out_agree}, 32'h1);
      chk("hold_rdy", {29'b0, rdy_vec()}, 32'h0);
      step();
    end
    vif.out_rdy = 1'b1;
    #1; chk("hold_hs_rdy", {29'b0, rdy_vec()}, 32'h0);
    step();
    vif.out_rdy = 1'b0;
    setv(3'b000);
    #1; chk("hold_drain", {31'b0, vif.out_val}, 32'h0);

    // Two votes only: round closes by timeout
    setm(8'hFF, 8'h0F, 8'h00);
    setv(3'b011);
    #1; chk("to_grant0", {29'b0, rdy_vec()}, 32'h1);
    step(); setv(3'b010);
    #1; chk("to_grant1", {29'b0, rdy_vec()}, 32'h2);
    step(); setv(3'b000);
    n = 1;
    while (!vif.out_val && n < 40) begin
      step();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_out_msg", {24'b0, vif.out_msg}, 32'h0F);
    chk("to_out_timeout", {31'b0, vif.out_timeout}, 32'h1);
    chk("to_out_agree", {31'b0, vif.out_agree}, 32'h0);
    vif.out_rdy = 1'b1;
    step();

    // Fairness with every requester always requesting
    setm(8'h01, 8'h02, 8'h04);
    setv(3'b111);
    for (int k = 0; k < 8; k++) begin
      #1; chk("fair_grant", {29'b0, rdy_vec()}, {29'b0, exp5[k]});
      step();
    end
    setv(3'b000);

    // Reset after two captures discards the round
    setm(8'h33, 8'h33, 8'h33);
    setv(3'b101);
    #1; chk("rr_grant2", {29'b0, rdy_vec()}, 32'h4);
    step(); setv(3'b001);
    #1; chk("rr_grant0", {29'b0, rdy_vec()}, 32'h1);
    step(); setv(3'b000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    setm(8'h00, 8'h55, 8'h00);
    setv(3'b010);
    #1;
    chk("rr_no_stale", {31'b0, vif.out_val}, 32'h0);
    chk("rr_grant1", {29'b0, rdy_vec()}, 32'h2);
    step(); setv(3'b000);
    n = 0;
    while (!vif.out_val && n < 40) begin
      step();
      n++;
    end
    chk("rr_latency", n, 16);
    chk("rr_out_msg", {24'b0, vif.out_msg}, 32'h00);
    chk("rr_out_timeout", {31'b0, vif.out_timeout}, 32'h1);
    vif.out_rdy = 1'b1;
    step();
    vif.out_rdy = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
